// File: rtl/mov_wide_unit_if.sv
// Handshake bundle for the move-wide unit: op request side (in_*) and result side (out_*).
// slave = the unit itself, master = whoever feeds ops and drains results.
interface mov_wide_unit_if #(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 16,
    parameter int REG_W  = 5
);
    localparam int SHAMT_W = $clog2(DATA_W / IMM_W);

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [REG_W-1:0]    in_rd;
    logic [DATA_W-1:0]   in_rd_data;
    logic [IMM_W-1:0]    in_imm;
    logic [SHAMT_W-1:0]  in_shamt;

    logic                out_valid;
    logic                out_ready;
    logic [REG_W-1:0]    out_rd;
    logic [DATA_W-1:0]   out_data;
    logic                out_illegal;

    modport slave (
        input  in_valid, in_op, in_rd, in_rd_data, in_imm, in_shamt, out_ready,
        output in_ready, out_valid, out_rd, out_data, out_illegal
    );

    modport master (
        output in_valid, in_op, in_rd, in_rd_data, in_imm, in_shamt, out_ready,
        input  in_ready, out_valid, out_rd, out_data, out_illegal
    );
endinterface

// File: rtl/mov_wide_unit.sv
// Two-stage MOVZ/MOVK/MOVN execution unit with in-flight result forwarding
// into MOVK bases so constant-building chains issue back to back.

// One IMM_W-wide slice of the result; each instance owns slice IDX.
module mov_wide_slice #(
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 2,
    parameter int IDX     = 0
) (
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [IMM_W-1:0]   imm,
    input  logic [IMM_W-1:0]   base,
    output logic [IMM_W-1:0]   res
);
    localparam logic [SHAMT_W-1:0] SEL = SHAMT_W'(IDX);

    logic             hit;
    logic [IMM_W-1:0] zval;

    assign hit  = (shamt == SEL);
    assign zval = hit ? imm : '0;

    always_comb begin
        res = '0;
        case (op)
            2'b00:   res = hit ? imm : base;
            2'b01:   res = zval;
            2'b10:   res = ~zval;
            default: res = '0;
        endcase
    end
endmodule

module mov_wide_unit #(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 16,
    parameter int REG_W  = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    mov_wide_unit_if.slave io
);
    localparam int NSLICE  = DATA_W / IMM_W;
    localparam int SHAMT_W = $clog2(NSLICE);
    localparam logic [REG_W-1:0] ZR = '1;

    typedef struct packed {
        logic [1:0]         op;
        logic [REG_W-1:0]   rd;
        logic [DATA_W-1:0]  base;
        logic [IMM_W-1:0]   imm;
        logic [SHAMT_W-1:0] shamt;
    } s1_t;

    typedef struct packed {
        logic              illegal;
        logic              fwd;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } s2_t;

    // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid
    logic [2:1]        vld_pipe_q, vld_pipe_d;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;

    logic              s1_adv, s2_adv;
    logic              s1_fwd;
    logic [DATA_W-1:0] s1_res;
    logic [DATA_W-1:0] base_sel;

    assign s2_adv      = !vld_pipe_q[2] || io.out_ready;
    assign s1_adv      = !vld_pipe_q[1] || s2_adv;
    assign io.in_ready = s1_adv;

    assign s1_fwd = (s1_q.op != 2'b11) && (s1_q.rd != ZR);

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        mov_wide_slice #(
            .IMM_W  (IMM_W),
            .SHAMT_W(SHAMT_W),
            .IDX    (g)
        ) u_slice (
            .op   (s1_q.op),
            .shamt(s1_q.shamt),
            .imm  (s1_q.imm),
            .base (s1_q.base[g*IMM_W +: IMM_W]),
            .res  (s1_res[g*IMM_W +: IMM_W])
        );
    end

    // The op in S1 is always younger than S2, so it wins when both match.
    always_comb begin
        base_sel = io.in_rd_data;
        if (io.in_rd == ZR)
            base_sel = '0;
        else if (vld_pipe_q[1] && s1_adv && s1_fwd && (s1_q.rd == io.in_rd))
            base_sel = s1_res;
        else if (vld_pipe_q[2] && s2_q.fwd && (s2_q.rd == io.in_rd))
            base_sel = s2_q.data;
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_d       = s1_q;
        s2_d       = s2_q;

        if (s1_adv) begin
            vld_pipe_d[1] = io.in_valid;
            if (io.in_valid) begin
                s1_d.op    = io.in_op;
                s1_d.rd    = io.in_rd;
                s1_d.base  = base_sel;
                s1_d.imm   = io.in_imm;
                s1_d.shamt = io.in_shamt;
            end
        end

        if (s2_adv) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                s2_d.illegal = (s1_q.op == 2'b11);
                s2_d.fwd     = s1_fwd;
                s2_d.rd      = s1_q.rd;
                s2_d.data    = s1_res;
            end
        end

        if (flush)
            vld_pipe_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign io.out_valid   = vld_pipe_q[2];
    assign io.out_rd      = s2_q.rd;
    assign io.out_data    = s2_q.data;
    assign io.out_illegal = s2_q.illegal;
endmodule

// File: tb/tb_mov_wide_unit.sv
// Directed bench for mov_wide_unit: hand-computed results collected from the
// output handshake and compared in order, plus reset, backpressure and flush probes.
module tb_mov_wide_unit;
    logic clk = 1'b0;
    logic reset_n;
    logic flush;

    always #5 clk = ~clk;

    mov_wide_unit_if #(.DATA_W(64), .IMM_W(16), .REG_W(5)) io ();
    mov_wide_unit_if #(.DATA_W(32), .IMM_W(16), .REG_W(5)) io32 ();

    mov_wide_unit #(.DATA_W(64), .IMM_W(16), .REG_W(5)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .io(io)
    );
    mov_wide_unit #(.DATA_W(32), .IMM_W(16), .REG_W(5)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .io(io32)
    );

    localparam logic [1:0] MOVK = 2'b00, MOVZ = 2'b01, MOVN = 2'b10, ILL = 2'b11;

    int n_chk = 0;
    int n_err = 0;
    logic [69:0] got_q[$];
    logic [69:0] exp_q[$];
    logic [5:0]  pat = 6'b101001;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [69:0] ent(input logic ill, input logic [4:0] rd, input logic [63:0] d);
        return {ill, rd, d};
    endfunction

    always @(negedge clk)
        if (io.out_valid && io.out_ready)
            got_q.push_back({io.out_illegal, io.out_rd, io.out_data});

    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [63:0] rdd,
                        input logic [15:0] imm, input logic [1:0] sh);
        bit acc = 1'b0;
        int k   = 0;
        io.in_valid   = 1'b1;
        io.in_op      = op;
        io.in_rd      = rd;
        io.in_rd_data = rdd;
        io.in_imm     = imm;
        io.in_shamt   = sh;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = io.in_ready;
            tick();
            k++;
        end
        io.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic check_q(input string tag);
        int k = 0;
        while (got_q.size() < exp_q.size() && k < 200) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        io.in_valid = 0; io.in_op = 0; io.in_rd = 0; io.in_rd_data = 0;
        io.in_imm = 0; io.in_shamt = 0; io.out_ready = 1;
        io32.in_valid = 0; io32.in_op = 0; io32.in_rd = 0; io32.in_rd_data = 0;
        io32.in_imm = 0; io32.in_shamt = 0; io32.out_ready = 1;
        flush = 0;
        reset_n = 0;

        #12;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_data", io.out_data, 0);
        chk("rst_out_rd", io.out_rd, 0);
        chk("rst_out_illegal", io.out_illegal, 0);
        chk("rst_in_ready", io.in_ready, 1);
        @(negedge clk);
        reset_n = 1;
        tick();
        chk("post_rst_in_ready", io.in_ready, 1);

        // two-cycle latency
        send(MOVZ, 5'd1, 64'h0, 16'h1234, 2'd1);
        chk("lat_t1_valid", io.out_valid, 0);
        tick();
        chk("lat_t2_valid", io.out_valid, 1);
        chk("lat_data", io.out_data, 64'h0000_0000_1234_0000);
        chk("lat_rd", io.out_rd, 1);
        tick();
        got_q.delete();

        // back-to-back constant build, no stall
        exp_q.push_back(ent(0, 2, 64'h0000_0000_0000_BEEF));
        exp_q.push_back(ent(0, 2, 64'h0000_0000_DEAD_BEEF));
        exp_q.push_back(ent(0, 2, 64'h0000_CAFE_DEAD_BEEF));
        exp_q.push_back(ent(0, 2, 64'h0123_CAFE_DEAD_BEEF));
        send(MOVZ, 5'd2, '1, 16'hBEEF, 2'd0);
        send(MOVK, 5'd2, '1, 16'hDEAD, 2'd1);
        send(MOVK, 5'd2, '1, 16'hCAFE, 2'd2);
        send(MOVK, 5'd2, '1, 16'h0123, 2'd3);
        check_q("chain");

        // same chain under out_ready 1,0,0,1,0,1
        exp_q.push_back(ent(0, 2, 64'h0000_0000_0000_BEEF));
        exp_q.push_back(ent(0, 2, 64'h0000_0000_DEAD_BEEF));
        exp_q.push_back(ent(0, 2, 64'h0000_CAFE_DEAD_BEEF));
        exp_q.push_back(ent(0, 2, 64'h0123_CAFE_DEAD_BEEF));
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    io.out_ready = pat[i];
                    tick();
                end
                io.out_ready = 1;
            end
            begin
                send(MOVZ, 5'd2, '1, 16'hBEEF, 2'd0);
                send(MOVK, 5'd2, '1, 16'hDEAD, 2'd1);
                send(MOVK, 5'd2, '1, 16'hCAFE, 2'd2);
                send(MOVK, 5'd2, '1, 16'h0123, 2'd3);
            end
        join
        check_q("chain_bp");

        // one-cycle gap: base must come from S2
        exp_q.push_back(ent(0, 9, 64'h0000_00FF_0000_0000));
        exp_q.push_back(ent(0, 9, 64'h0000_00FF_0000_0F0F));
        send(MOVZ, 5'd9, 64'h0, 16'h00FF, 2'd2);
        tick();
        send(MOVK, 5'd9, '1, 16'h0F0F, 2'd0);
        check_q("s2_fwd");

        // MOVN and illegal
        exp_q.push_back(ent(0, 3, 64'hFFFE_FFFF_FFFF_FFFF));
        exp_q.push_back(ent(0, 4, 64'hFFFF_FFFF_FFFF_FFFF));
        exp_q.push_back(ent(1, 5, 64'h0));
        exp_q.push_back(ent(0, 5, 64'h0000_0000_AAAA_1111));
        send(MOVN, 5'd3, 64'h0, 16'h0001, 2'd3);
        send(MOVN, 5'd4, 64'h0, 16'h0000, 2'd0);
        send(ILL,  5'd5, 64'h0, 16'h5A5A, 2'd1);
        send(MOVK, 5'd5, 64'h0000_0000_AAAA_0000, 16'h1111, 2'd0);
        check_q("movn_ill");

        // zero register and mismatched rd
        exp_q.push_back(ent(0, 31, 64'h0000_0000_0000_AAAA));
        exp_q.push_back(ent(0, 31, 64'h0000_0000_5555_0000));
        exp_q.push_back(ent(0, 6, 64'h0000_0000_0000_0001));
        exp_q.push_back(ent(0, 7, 64'h1000_0000_0002_0000));
        send(MOVZ, 5'd31, 64'h0, 16'hAAAA, 2'd0);
        send(MOVK, 5'd31, 64'h77, 16'h5555, 2'd1);
        send(MOVZ, 5'd6, 64'h0, 16'h0001, 2'd0);
        send(MOVK, 5'd7, 64'h1000_0000_0000_0000, 16'h0002, 2'd1);
        check_q("zr");

        // backpressure fills both stages, then flush
        io.out_ready = 0;
        io.in_valid = 1; io.in_op = MOVZ; io.in_rd = 5'd8; io.in_rd_data = 0;
        io.in_imm = 16'h0001; io.in_shamt = 0;
        @(negedge clk);
        chk("bp_rdy_a", io.in_ready, 1);
        tick();
        io.in_imm = 16'h0002;
        @(negedge clk);
        chk("bp_rdy_b", io.in_ready, 1);
        tick();
        io.in_imm = 16'h0003;
        @(negedge clk);
        chk("bp_rdy_c", io.in_ready, 0);
        chk("bp_out_valid", io.out_valid, 1);
        chk("bp_out_data", io.out_data, 64'h1);
        tick();
        @(negedge clk);
        chk("bp_hold_data", io.out_data, 64'h1);
        chk("bp_hold_rdy", io.in_ready, 0);
        tick();
        flush = 1;
        io.out_ready = 1;
        exp_q.push_back(ent(0, 8, 64'h1));
        tick();
        flush = 0;
        io.in_valid = 0;
        chk("flush_out_valid", io.out_valid, 0);
        chk("flush_in_ready", io.in_ready, 1);
        for (int i = 0; i < 4; i++) tick();
        exp_q.push_back(ent(0, 8, 64'h0000_0000_0002_0000));
        send(MOVK, 5'd8, 64'h0, 16'h0002, 2'd1);
        check_q("flush");

        // asynchronous reset mid-stream
        io.out_ready = 0;
        send(MOVZ, 5'd10, 64'h0, 16'hFFFF, 2'd3);
        tick();
        chk("pre_rst_valid", io.out_valid, 1);
        #2;
        reset_n = 0;
        #1;
        chk("mid_rst_valid", io.out_valid, 0);
        chk("mid_rst_data", io.out_data, 0);
        chk("mid_rst_rd", io.out_rd, 0);
        chk("mid_rst_in_ready", io.in_ready, 1);
        @(negedge clk);
        reset_n = 1;
        io.out_ready = 1;
        tick();
        got_q.delete();

        // 32-bit instance, single select bit
        io32.in_valid = 1; io32.in_op = MOVK; io32.in_rd = 5'd3;
        io32.in_rd_data = 32'h1111_2222; io32.in_imm = 16'hABCD; io32.in_shamt = 1'b1;
        @(negedge clk);
        chk("w32_in_ready", io32.in_ready, 1);
        tick();
        io32.in_valid = 0;
        chk("w32_t1_valid", io32.out_valid, 0);
        tick();
        chk("w32_valid", io32.out_valid, 1);
        chk("w32_data", io32.out_data, 32'hABCD_2222);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mov_wide_unit.md
# mov_wide_unit

Pipelined, parametrised move-wide execution unit for MOVZ, MOVK and MOVN. It inserts an IMM_W-bit immediate into one IMM_W-aligned slice of a DATA_W-bit result. Two internal stages and valid/ready handshakes on both sides let it sit in the execute stage of the pipelined CPU. It forwards in-flight results into later MOVK instructions, so back-to-back MOVZ/MOVK chains that build wide constants are correct without register-file round trips.

## Interface
- DATA_W, 64, datapath width; must equal IMM_W × 2^k with k ≥ 1.
- IMM_W, 16, immediate and slice width.
- REG_W, 5, destination register index width; all-ones index is the zero register (ZR).
- SHAMT_W, derived as log2(DATA_W/IMM_W), slice select width (2 for defaults).
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  input op present.
- in_ready  out  1  unit accepts the op this cycle.
- in_op  in  2  00 MOVK, 01 MOVZ, 10 MOVN, 11 illegal.
- in_rd  in  REG_W  destination register.
- in_rd_data  in  DATA_W  register-file value of in_rd (MOVK base).
- in_imm  in  IMM_W  immediate.
- in_shamt  in  SHAMT_W  slice index; the shift is in_shamt × IMM_W.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_rd  out  REG_W  destination of the result.
- out_data  out  DATA_W  result value.
- out_illegal  out  1  result came from op 11.

## Operation
- Slice s covers bits [s·IMM_W+IMM_W-1 : s·IMM_W].
- MOVZ: slice s = imm; all other bits 0.
- MOVN: bitwise NOT of the MOVZ value.
- MOVK: slice s = imm; all other bits taken from the base.
- Illegal (op 11): out_data = 0, out_illegal = 1. The op is never a forwarding source.
- Stage S1 registers the op and the resolved MOVK base. Result logic evaluates from the S1 registers. Stage S2 registers the result, which drives the out_* ports.
- MOVK base is resolved at S1 capture, highest priority first:
  - S1 result, when S1 is advancing this edge with a legal op to the same rd.
  - S2 result, when S2 is valid with a legal op to the same rd. This applies even if S2 is leaving this edge.
  - in_rd_data otherwise.
- ZR rules: when in_rd = ZR, the base is 0 and no forwarding occurs. Ops to ZR are never forwarding sources. Ops to ZR still produce a result and report out_rd = ZR.
- The base is fixed after capture. Only older ops can supply it, and their values never change afterwards.

## Timing
- s2_adv = !s2_valid | out_ready.
- s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv. It is combinational, with no dependency on in_valid.
- An op accepted at the end of cycle t appears on out_* in cycle t+2 when there is no backpressure. Throughput is 1 op/cycle.
- out_valid held with !out_ready: all out_* remain stable. S1 holds while it is valid. in_ready drops once both stages are valid.
- Ordering is strictly in order. No op is dropped or duplicated under any out_ready pattern.
- flush = 1 at an edge:
  - s1_valid and s2_valid clear.
  - Any simultaneous input handshake is discarded.
  - Any simultaneous output handshake still counts as consumed.
- reset_n low, asynchronously and including mid-operation:
  - s1_valid = s2_valid = 0.
  - out_data = 0, out_rd = 0, out_illegal = 0.
  - All S1 registers = 0.
  - in_ready = 1 while reset_n = 0 and on the first cycle after release.
- Simultaneous S2 drain, S1 advance and new input resolve in the same cycle, with the forwarding priority above.

## Test plan
- MOVZ rd=1 imm=0x1234 shamt=1, out_ready=1 -> out_data 0x0000_0000_1234_0000, out_rd 1, out_valid two cycles after accept.
- Back-to-back rd=2 with in_rd_data held at 0xFFFF_FFFF_FFFF_FFFF:
  - Stimulus: MOVZ 0xBEEF s0, then MOVK 0xDEAD s1, MOVK 0xCAFE s2, MOVK 0x0123 s3.
  - Required: final out_data 0x0123_CAFE_DEAD_BEEF, with intermediates matching each step.
  - Repeat with out_ready toggling 1,0,0,1,0,1 -> same values, same order.
- MOVN imm=0x0001 s3 -> 0xFFFE_FFFF_FFFF_FFFF. MOVN imm=0 s0 -> all ones. Op 11 -> out_data 0, out_illegal 1, and a following MOVK to the same rd uses in_rd_data.
- ZR cases:
  - MOVZ rd=31 0xAAAA s0, then MOVK rd=31 0x5555 s1 with in_rd_data=0x77 -> second result 0x0000_0000_5555_0000 (no forwarding).
  - Forwarding with a different rd -> in_rd_data is used.
- Backpressure and flush:
  - out_ready=0, three ops offered -> two accepted, in_ready=0 on the third.
  - Assert flush -> next cycle out_valid=0, in_ready=1, and no flushed result ever appears.
  - Reset asserted mid-stream -> all outputs 0 immediately.
- DATA_W=32, IMM_W=16 (SHAMT_W=1): MOVK imm=0xABCD s1, base 0x1111_2222 -> 0xABCD_2222.
